// File: rtl/sr_driver.sv
// Driver/checker for an S/R latch: launches hold/set/reset commands, samples q after SETTLE cycles,
// and reports mismatches against an expected-state model. Define SR_DRIVER_PULSE_EN for one-cycle S/R pulses.
module sr_driver #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    output logic             S,
    output logic             R,
    input  logic             q_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_q,
    output logic             rsp_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    localparam logic [1:0] CMD_HOLD    = 2'b00;
    localparam logic [1:0] CMD_SET     = 2'b01;
    localparam logic [1:0] CMD_RESET   = 2'b10;
    localparam logic [1:0] CMD_ILLEGAL = 2'b11;

    localparam logic [7:0]       CNT_INIT = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_q_q, rsp_q_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             exp_known_q, exp_known_d;
    logic             exp_q, exp_d;
    logic             exp_upd, exp_known_upd;
    logic             load_err;

    // Expected latch state once the pending command has completed; hold leaves it as it was.
    always_comb begin
        exp_upd       = exp_q;
        exp_known_upd = exp_known_q;
        case (op_q)
            CMD_SET: begin
                exp_upd       = 1'b1;
                exp_known_upd = 1'b1;
            end
            CMD_RESET: begin
                exp_upd       = 1'b0;
                exp_known_upd = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        s_d         = s_q;
        r_d         = r_q;
        rsp_valid_d = rsp_valid_q;
        rsp_q_d     = rsp_q_q;
        rsp_err_d   = rsp_err_q;
        exp_d       = exp_q;
        exp_known_d = exp_known_q;
        load_err    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd;
                    if (cmd == CMD_ILLEGAL) begin
                        s_d         = 1'b0;
                        r_d         = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_q_d     = q_in;
                        rsp_err_d   = 1'b1;
                        load_err    = 1'b1;
                        state_d     = ST_REPORT;
                    end else begin
                        s_d     = (cmd == CMD_SET);
                        r_d     = (cmd == CMD_RESET);
                        cnt_d   = CNT_INIT;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    s_d         = 1'b0;
                    r_d         = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_q_d     = q_in;
                    exp_d       = exp_upd;
                    exp_known_d = exp_known_upd;
                    rsp_err_d   = exp_known_upd & (q_in != exp_upd);
                    load_err    = rsp_err_d;
                    state_d     = ST_REPORT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
`ifdef SR_DRIVER_PULSE_EN
                    s_d = 1'b0;
                    r_d = 1'b0;
`endif
                end
            end
            ST_REPORT: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        err_cnt_d = err_cnt_q;
        if (load_err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            op_q        <= CMD_HOLD;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            exp_known_q <= 1'b0;
            exp_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            s_q         <= s_d;
            r_q         <= r_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q_q     <= rsp_q_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
            exp_known_q <= exp_known_d;
            exp_q       <= exp_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign S         = s_q;
    assign R         = r_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_err   = rsp_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sr_driver.sv
// Directed bench for sr_driver (SETTLE=2, CNT_W=2) with a behavioural S/R latch driving q_in.
module tb_sr_driver;

    localparam int SETTLE = 2;
    localparam int CNT_W  = 2;
`ifdef SR_DRIVER_PULSE_EN
    localparam int S_HI = 1;
`else
    localparam int S_HI = SETTLE;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd;
    logic             S;
    logic             R;
    logic             q_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_q;
    logic             rsp_err;
    logic [CNT_W-1:0] err_cnt;

    logic latch_q = 1'b0;
    logic force_en;
    logic force_val;

    int n_checks = 0;
    int n_fail   = 0;
    int both_seen = 0;
    int lat, s_hi, r_hi;

    sr_driver #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .S(S), .R(R), .q_in(q_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_err(rsp_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural latch; force_en overrides it to emulate a stuck or faulty latch.
    always @(posedge clk) begin
        if (S) latch_q <= 1'b1;
        else if (R) latch_q <= 1'b0;
    end
    assign q_in = force_en ? force_val : latch_q;

    always @(negedge clk) if (S && R) both_seen++;

    // Launch a command from IDLE; returns edges from accept to rsp_valid and S/R high-cycle counts.
    task automatic run_cmd(input logic [1:0] c);
        lat = 0; s_hi = 0; r_hi = 0;
        cmd = c; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!rsp_valid && lat < 20) begin
            if (S) s_hi++;
            if (R) r_hi++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        logic saved;
        saved = rsp_ready;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = saved;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_checks++; if ({S, R} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_sr: got %b want 00", {S, R}); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if ({rsp_q, rsp_err} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rsp: got %b want 00", {rsp_q, rsp_err}); end
        n_checks++; if (err_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_set();
        run_cmd(2'b01);
        n_checks++; if (lat !== SETTLE) begin n_fail++; $display("[TB] FAIL set_latency: got %0d want %0d", lat, SETTLE); end
        n_checks++; if (s_hi !== S_HI) begin n_fail++; $display("[TB] FAIL set_s_cycles: got %0d want %0d", s_hi, S_HI); end
        n_checks++; if (r_hi !== 0) begin n_fail++; $display("[TB] FAIL set_r_cycles: got %0d want 0", r_hi); end
        n_checks++; if ({S, R} !== 2'b00) begin n_fail++; $display("[TB] FAIL set_sr_at_report: got %b want 00", {S, R}); end
        n_checks++; if ({rsp_q, rsp_err} !== 2'b10) begin n_fail++; $display("[TB] FAIL set_rsp: got q/err %b want 10", {rsp_q, rsp_err}); end
        n_checks++; if (err_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL set_err_cnt: got %0d want 0", err_cnt); end
        finish_rsp();
        n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL set_handshake: got valid/ready %b want 01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] cmds [3];
        logic       qs   [3];
        cmds = '{2'b01, 2'b10, 2'b01};
        qs   = '{1'b1, 1'b0, 1'b1};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cmd(cmds[i]);
            n_checks++; if ({rsp_q, rsp_err} !== {qs[i], 1'b0}) begin n_fail++; $display("[TB] FAIL b2b_rsp[%0d]: got q/err %b want %b", i, {rsp_q, rsp_err}, {qs[i], 1'b0}); end
            finish_rsp();
        end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_idle: got %b want 1", cmd_ready); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_hold_and_mismatch();
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        force_en = 1'b1; force_val = 1'b1;
        run_cmd(2'b00);
        n_checks++; if (lat !== SETTLE || s_hi !== 0 || r_hi !== 0) begin n_fail++; $display("[TB] FAIL hold_drive: got lat %0d s %0d r %0d want %0d 0 0", lat, s_hi, r_hi, SETTLE); end
        n_checks++; if ({rsp_q, rsp_err} !== 2'b10) begin n_fail++; $display("[TB] FAIL hold_unknown_rsp: got q/err %b want 10", {rsp_q, rsp_err}); end
        finish_rsp();
        run_cmd(2'b10);
        n_checks++; if ({rsp_q, rsp_err} !== 2'b11) begin n_fail++; $display("[TB] FAIL reset_forced_rsp: got q/err %b want 11", {rsp_q, rsp_err}); end
        n_checks++; if (err_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL reset_forced_err_cnt: got %0d want 1", err_cnt); end
        finish_rsp();
        force_en = 1'b0;
    endtask

    task automatic test_illegal();
        run_cmd(2'b11);
        n_checks++; if (lat !== 0) begin n_fail++; $display("[TB] FAIL illegal_latency: got %0d want 0 edges after accept", lat); end
        n_checks++; if ({S, R} !== 2'b00) begin n_fail++; $display("[TB] FAIL illegal_sr: got %b want 00", {S, R}); end
        n_checks++; if ({rsp_q, rsp_err} !== 2'b01) begin n_fail++; $display("[TB] FAIL illegal_rsp: got q/err %b want 01", {rsp_q, rsp_err}); end
        n_checks++; if (err_cnt !== 2'd2) begin n_fail++; $display("[TB] FAIL illegal_err_cnt: got %0d want 2", err_cnt); end
        finish_rsp();
        run_cmd(2'b00);
        n_checks++; if ({rsp_q, rsp_err, err_cnt} !== 4'b0010) begin n_fail++; $display("[TB] FAIL illegal_model_kept: got q/err/cnt %b want 0010", {rsp_q, rsp_err, err_cnt}); end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int bad;
        logic q0, e0;
        bad = 0;
        run_cmd(2'b01);
        q0 = rsp_q; e0 = rsp_err;
        n_checks++; if ({q0, e0} !== 2'b10) begin n_fail++; $display("[TB] FAIL bp_rsp: got q/err %b want 10", {q0, e0}); end
        cmd = 2'b10; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_q !== q0 || rsp_err !== e0 || cmd_ready !== 1'b0) bad++;
        end
        cmd_valid = 1'b0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL bp_stable: got %0d unstable cycles want 0", bad); end
        finish_rsp();
        n_checks++; if ({rsp_valid, cmd_ready, err_cnt} !== 4'b0110) begin n_fail++; $display("[TB] FAIL bp_release: got valid/ready/cnt %b want 0110", {rsp_valid, cmd_ready, err_cnt}); end
    endtask

    task automatic test_reset_mid_settle();
        cmd = 2'b01; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++; if (S !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_s_driven: got %b want 1", S); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if ({S, R, rsp_valid, cmd_ready} !== 4'b0001) begin n_fail++; $display("[TB] FAIL mid_reset_outputs: got S/R/valid/ready %b want 0001", {S, R, rsp_valid, cmd_ready}); end
        n_checks++; if (err_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL mid_reset_err_cnt: got %0d want 0", err_cnt); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_dropped: got %b want 0", rsp_valid); end
        force_en = 1'b1; force_val = 1'b0;
        run_cmd(2'b00);
        n_checks++; if ({rsp_q, rsp_err} !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_reset_known_cleared: got q/err %b want 00", {rsp_q, rsp_err}); end
        finish_rsp();
    endtask

    task automatic test_saturation();
        int want [4];
        want = '{1, 2, 3, 3};
        force_en = 1'b1; force_val = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_cmd(2'b01);
            n_checks++; if (rsp_err !== 1'b1 || int'(err_cnt) !== want[i]) begin n_fail++; $display("[TB] FAIL sat[%0d]: got err %b cnt %0d want 1 %0d", i, rsp_err, err_cnt, want[i]); end
            n_checks++; if (s_hi !== S_HI) begin n_fail++; $display("[TB] FAIL sat_s_cycles[%0d]: got %0d want %0d", i, s_hi, S_HI); end
            finish_rsp();
        end
        rsp_ready = 1'b0;
        force_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; rsp_ready = 1'b0;
        force_en = 1'b0; force_val = 1'b0;
        test_reset();
        test_set();
        test_back_to_back();
        test_hold_and_mismatch();
        test_illegal();
        test_backpressure();
        test_reset_mid_settle();
        test_saturation();
        n_checks++; if (both_seen !== 0) begin n_fail++; $display("[TB] FAIL sr_exclusive: got %0d cycles with S=R=1 want 0", both_seen); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
